// File: rtl/i2c_nios_i2c_master.sv
// Avalon-MM I2C byte master (START / WR|RD / ACK / STOP); clock stretching under I2C_NIOS_I2C_MASTER_CLK_STRETCH_EN.
// Zero-wait-state register reads; CMD accepted next edge, CMD writes while busy are dropped (sticky DROPPED).
module i2c_nios_i2c_master #(
  parameter logic [15:0] DEFAULT_DIV = 16'd124
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  input  logic        scl_in,
  input  logic        sda_in,
  output logic        scl_oe,
  output logic        sda_oe
);
  typedef enum logic [2:0] {S_IDLE, S_START, S_BYTE, S_ACK, S_STOP} state_t;
  state_t state, state_nxt;

  logic [7:0]  tx_byte, rx_byte, tx_sh, rx_sh;
  logic [15:0] div, div_act, qcnt;
  logic [1:0]  q;
  logic [2:0]  bitcnt;
  logic        cmd_stop, cmd_wr, cmd_rd, cmd_ack;
  logic        rx_nack, dropped;
  logic        scl_q, sda_q;
  logic        busy, wr_en, cmd_wr_en, cmd_ok, accept, freeze, qtick, phase_done, samp;

  assign busy       = (state != S_IDLE);
  assign wr_en      = chipselect & ~write_n;
  assign cmd_wr_en  = wr_en & (address == 2'd1);
  assign cmd_ok     = (|writedata[3:0]) & ~(writedata[2] & writedata[3]);
  assign accept     = cmd_wr_en & ~busy & cmd_ok;

`ifdef I2C_NIOS_I2C_MASTER_CLK_STRETCH_EN
  // A slave holding SCL low during a released quarter stalls the quarter counter.
  assign freeze = busy & ~scl_oe & ~scl_in;
  logic unused_bits;
  assign unused_bits = ^writedata[31:16];
`else
  assign freeze = 1'b0;
  logic unused_bits;
  assign unused_bits = ^{writedata[31:16], scl_in};
`endif

  assign qtick      = busy & ~freeze & (qcnt == div_act);
  assign phase_done = qtick & (q == 2'd3);
  assign samp       = qtick & (q == 2'd1);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (accept) begin
          if (writedata[0])                     state_nxt = S_START;
          else if (writedata[2] | writedata[3]) state_nxt = S_BYTE;
          else                                  state_nxt = S_STOP;
        end
      end
      S_START: begin
        if (phase_done) begin
          if (cmd_wr | cmd_rd) state_nxt = S_BYTE;
          else if (cmd_stop)   state_nxt = S_STOP;
          else                 state_nxt = S_IDLE;
        end
      end
      S_BYTE:  if (phase_done && bitcnt == 3'd7) state_nxt = S_ACK;
      S_ACK:   if (phase_done) state_nxt = cmd_stop ? S_STOP : S_IDLE;
      S_STOP:  if (phase_done) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Idle holds the last driven levels, so a command without STOP leaves SCL low for a repeated start.
  always_comb begin
    scl_oe = scl_q;
    sda_oe = sda_q;
    case (state)
      S_START: begin
        case (q)
          2'd0: begin
            sda_oe = 1'b0;
            scl_oe = (qcnt == 16'd0) ? scl_q : 1'b0;
          end
          2'd1:    begin sda_oe = 1'b1; scl_oe = 1'b0; end
          default: begin sda_oe = 1'b1; scl_oe = 1'b1; end
        endcase
      end
      S_BYTE: begin
        sda_oe = cmd_wr & ~tx_sh[~bitcnt];
        scl_oe = (q == 2'd0) | (q == 2'd3);
      end
      S_ACK: begin
        sda_oe = cmd_rd & ~cmd_ack;
        scl_oe = (q == 2'd0) | (q == 2'd3);
      end
      S_STOP: begin
        case (q)
          2'd0:    begin sda_oe = 1'b1; scl_oe = 1'b1; end
          2'd1:    begin sda_oe = 1'b1; scl_oe = 1'b0; end
          default: begin sda_oe = 1'b0; scl_oe = 1'b0; end
        endcase
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      qcnt   <= '0;
      q      <= '0;
      bitcnt <= '0;
    end else if (accept) begin
      qcnt   <= '0;
      q      <= '0;
      bitcnt <= '0;
    end else if (busy && !freeze) begin
      if (qcnt == div_act) begin
        qcnt <= '0;
        q    <= q + 2'd1;
        if (q == 2'd3 && state == S_BYTE) bitcnt <= bitcnt + 3'd1;
      end else begin
        qcnt <= qcnt + 16'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tx_byte  <= '0;
      rx_byte  <= '0;
      tx_sh    <= '0;
      rx_sh    <= '0;
      div      <= DEFAULT_DIV;
      div_act  <= DEFAULT_DIV;
      cmd_stop <= 1'b0;
      cmd_wr   <= 1'b0;
      cmd_rd   <= 1'b0;
      cmd_ack  <= 1'b0;
      rx_nack  <= 1'b0;
      dropped  <= 1'b0;
      scl_q    <= 1'b0;
      sda_q    <= 1'b0;
    end else begin
      scl_q <= scl_oe;
      sda_q <= sda_oe;
      if (wr_en && address == 2'd0) tx_byte <= writedata[7:0];
      if (wr_en && address == 2'd2) div     <= writedata[15:0];
      if (accept) begin
        div_act  <= div;
        tx_sh    <= tx_byte;
        cmd_stop <= writedata[1];
        cmd_wr   <= writedata[2];
        cmd_rd   <= writedata[3];
        cmd_ack  <= writedata[4];
        dropped  <= 1'b0;
      end else if (cmd_wr_en && busy && !(writedata[2] && writedata[3])) begin
        dropped <= 1'b1;
      end
      if (samp && state == S_BYTE && cmd_rd) rx_sh   <= {rx_sh[6:0], sda_in};
      if (samp && state == S_ACK && cmd_wr)  rx_nack <= sda_in;
      // Received byte becomes visible only once its ACK bit has completed.
      if (phase_done && state == S_ACK && cmd_rd) rx_byte <= rx_sh;
    end
  end

  always_comb begin
    readdata = '0;
    case (address)
      2'd0:    readdata[7:0]  = rx_byte;
      2'd1:    readdata[2:0]  = {dropped, rx_nack, busy};
      2'd2:    readdata[15:0] = div;
      default: readdata       = '0;
    endcase
  end
endmodule
